// File: rtl/inst_rom_responder.sv
// Instruction-fetch responder: word-addressed instruction memory with a fixed response latency,
// alignment/range fault checking, redirect cancellation and a word-write load port.
module inst_rom_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  inst_fault,
  output logic                  busy,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned SHIFT    = ADDR_WIDTH + 2;
  localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_cnt;
  logic [1:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_fault;
  logic                  r_ready;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_inst_fault;
  logic [31:0]           r_inst;
  logic [31:0]           r_mem [DEPTH];

  logic [31:0]           w_diff;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_fault;

  // Address decode of the incoming request
  assign w_diff   = req_addr - BASE_ADDR;
  assign w_idx    = w_diff[ADDR_WIDTH+1:2];
  assign w_fault  = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) |
                    ((w_diff >> SHIFT) != 32'd0);
  assign w_accept = req_valid & r_ready & ~flush;

  // Single-edge latency reads the request being accepted; longer latencies read the latched one
  assign w_rd_idx   = (LATENCY == 1) ? w_idx   : r_idx;
  assign w_rd_fault = (LATENCY == 1) ? w_fault : r_fault;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A redirect drops everything, including a same-cycle accept
    if (flush) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = 2'd0;
      w_enter_resp = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_idx        <= '0;
      r_fault      <= 1'b0;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_inst       <= RESET_INST;
      r_inst_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESP);
      r_valid <= w_enter_resp;
      r_busy  <= (w_state_nxt == S_WAIT);
      if (w_accept) begin
        r_idx   <= w_idx;
        r_fault <= w_fault;
      end
      if (w_enter_resp) begin
        r_inst       <= w_rd_fault ? 32'd0 : r_mem[w_rd_idx];
        r_inst_fault <= w_rd_fault;
      end
    end
  end

  // Program-load port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  assign req_ready  = r_ready;
  assign inst_valid = r_valid;
  assign inst_fault = r_inst_fault;
  assign inst       = r_inst;
  assign busy       = r_busy;

endmodule

// File: doc/inst_rom_responder.md
# inst_rom_responder

Responder side of the instruction-fetch interface of the five-stage pipelined CPU. Holds the instruction memory array, accepts one fetch request at a time from the IF stage, and returns the addressed 32-bit instruction after a fixed, parameterised latency. It also checks alignment and range, cancels an outstanding request on a pipeline redirect, and provides a word-write port for program loading.

## Interface
- ADDR_WIDTH, 8: word-index bits; the array holds 2^ADDR_WIDTH words.
- LATENCY, 1: edges from accept to response, legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- RESET_INST, 32'h0000_0000: value of `inst` after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address of the request.
- req_ready  out  1  request can be accepted this cycle.
- flush  in  1  cancels any outstanding request (branch or exception redirect).
- inst  out  32  returned instruction; held between responses.
- inst_valid  out  1  one-cycle response strobe.
- inst_fault  out  1  qualifies `inst_valid`; the request was misaligned or out of range.
- busy  out  1  a request is outstanding.
- load_en  in  1  word write enable.
- load_addr  in  ADDR_WIDTH  word index for the write.
- load_data  in  32  write data.

## Operation
- States:
  - IDLE: nothing outstanding.
  - WAIT: request accepted, latency counting.
  - RESP: `inst_valid` high.
- Accept condition: `req_valid & req_ready & ~flush`.
  - On accept, latch the address and compute the fault flag.
  - Load the 2-bit counter with LATENCY-1.
- `req_ready` = (state is IDLE or RESP).
  - Back-to-back requests are accepted in the RESP cycle.
- Fault flag is set on any of:
  - `req_addr[1:0] != 0`;
  - `req_addr < BASE_ADDR`;
  - `((req_addr - BASE_ADDR) >> 2) >= 2^ADDR_WIDTH`.
  - The subtraction is 32-bit unsigned; word index = bits [ADDR_WIDTH+1:2] of the difference.
- Transitions:
  - IDLE/RESP on accept: go to RESP if LATENCY==1, else go to WAIT.
  - WAIT: decrement the counter each edge. At the edge where it reaches 0, go to RESP.
  - RESP with no accept: go to IDLE.
  - Any state with `flush=1`: go to IDLE, no response produced. `flush` overrides a same-cycle accept.
- On entering RESP:
  - Non-fault request: `inst` = array[latched index], `inst_fault`=0.
  - Fault request: `inst`=0, `inst_fault`=1. Fault responses keep the same latency.
- `inst` and `inst_fault` hold until the next RESP entry. `inst_valid` is high only in RESP.
- `busy` = (state is WAIT) or (`inst_valid` pending), i.e. state != IDLE and != RESP-without-new-accept; equivalently `busy` = state==WAIT.
- Load port:
  - `load_en` writes `load_data` to array[`load_addr`] at the edge.
  - Writes are allowed in every state.
- The array is not reset; contents are undefined until loaded.

## Timing
- Reset, asynchronous: state=IDLE, `inst`=RESET_INST, `inst_valid`=0, `inst_fault`=0, `busy`=0, counter=0. `req_ready`=1 right after reset.
- Request accepted at edge n: `inst_valid` rises at edge n+LATENCY-1 and falls at the next edge unless another response follows.
- Throughput: one response every LATENCY edges. With LATENCY=1 it is one response per cycle.
- Array read occurs at the edge that enters RESP.
  - A write to the same word at an earlier edge is visible.
  - A write at that same edge returns the old data.
- `flush` in the RESP cycle does not retract the current `inst_valid`; it only blocks a new accept.
- `req_addr` is sampled only at accept; later changes are ignored.
- Reset asserted mid-request: the request is dropped immediately; no response after reset release.

## Test plan
- Load words 0..3 with 0x11111111..0x44444444, LATENCY=1, request 0x0,0x4,0x8,0xC on consecutive cycles -> `inst_valid` high 4 consecutive cycles, data in order, `inst_fault`=0.
- LATENCY=3, request 0x8 at edge 10 -> `inst_valid` exactly at edge 12 with 0x33333333; `req_ready`=0 and `busy`=1 at edges 10–11.
- LATENCY=3, request 0x4, `flush` one cycle later -> no `inst_valid`; state IDLE; next request 0xC responds 0x44444444 after 3 edges.
- Request 0x2, then 0x400 (ADDR_WIDTH=8, BASE_ADDR=0) -> both respond with `inst_fault`=1, `inst`=0, at normal latency.
- LATENCY=2, request 0x0 while `load_en` writes word 0 = 0xDEADBEEF at the edge after accept -> returns 0x11111111; a repeat request returns 0xDEADBEEF.
- Assert `resetn`=0 during WAIT -> outputs at reset values asynchronously; no stale `inst_valid` after release.
